// File: rtl/alu_share_arbiter.sv
// Two-port valid/ready arbiter time-sharing one combinational ALU, with a one-deep response slot per port.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module alu_share_arbiter #(
  parameter int unsigned     WIDTH   = 32,
  parameter int unsigned     OPW     = 4,
  parameter logic [OPW-1:0]  ALU_ADD = {OPW{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [OPW-1:0]   i_req0_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [OPW-1:0]   i_req1_op,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_data,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_data,
  output logic [OPW-1:0]   o_alu_op,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_out
);

  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp0_data;
  logic [WIDTH-1:0] r_rsp1_data;
  logic             w_free0;
  logic             w_free1;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;

  // A slot may drain and refill in the same cycle; nothing is granted while in reset.
  assign w_free0 = !r_rsp0_valid || i_rsp0_ready;
  assign w_free1 = !r_rsp1_valid || i_rsp1_ready;
  assign w_elig0 = i_req0_valid && w_free0 && !i_rst;
  assign w_elig1 = i_req1_valid && w_free1 && !i_rst;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic r_last;

  // Remember the most recently granted port; reset to 1 so port 0 wins the first contest.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (w_grant0) begin
      r_last <= 1'b0;
    end else if (w_grant1) begin
      r_last <= 1'b1;
    end else begin
      r_last <= r_last;
    end
  end
`endif

  // Grant selection: contested cycles follow the configured policy.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_elig0 && w_elig1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_grant0 = 1'b1;
`else
      if (r_last) begin
        w_grant0 = 1'b1;
      end else begin
        w_grant1 = 1'b1;
      end
`endif
    end else if (w_elig0) begin
      w_grant0 = 1'b1;
    end else if (w_elig1) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  // Steer the granted payload to the shared ALU; idle as ADD of zeros.
  always_comb begin
    o_alu_op = ALU_ADD;
    o_alu_a  = {WIDTH{1'b0}};
    o_alu_b  = {WIDTH{1'b0}};
    case ({w_grant1, w_grant0})
      2'b01: begin
        o_alu_op = i_req0_op;
        o_alu_a  = i_req0_a;
        o_alu_b  = i_req0_b;
      end
      2'b10: begin
        o_alu_op = i_req1_op;
        o_alu_a  = i_req1_a;
        o_alu_b  = i_req1_b;
      end
      default: begin
        o_alu_op = ALU_ADD;
        o_alu_a  = {WIDTH{1'b0}};
        o_alu_b  = {WIDTH{1'b0}};
      end
    endcase
  end

  // Response slot 0: capture on grant, otherwise empty when consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= {WIDTH{1'b0}};
    end else if (w_grant0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_data  <= i_alu_out;
    end else if (i_rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= r_rsp0_data;
    end else begin
      r_rsp0_valid <= r_rsp0_valid;
      r_rsp0_data  <= r_rsp0_data;
    end
  end

  // Response slot 1: same behaviour as slot 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= {WIDTH{1'b0}};
    end else if (w_grant1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_data  <= i_alu_out;
    end else if (i_rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= r_rsp1_data;
    end else begin
      r_rsp1_valid <= r_rsp1_valid;
      r_rsp1_data  <= r_rsp1_data;
    end
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp0_data  = r_rsp0_data;
  assign o_rsp1_data  = r_rsp1_data;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter that time-shares one combinational ALU (driven with `ALU_*` codes from ALUop.vh) between the main pipeline (port 0) and a secondary engine (port 1, e.g. address/CSR helper). Each port has a valid/ready request channel and a valid/ready response channel. Each accepted operation is steered through the shared ALU and its result is registered into a one-deep per-port response slot.

## Interface
- `WIDTH`, 32: operand/result width.
- `OPW`, 4: ALUop width; must match ALUop.vh.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when valid&ready.
- `req0_op`, `req1_op`  in  OPW  ALU operation code.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `rsp0_valid`, `rsp1_valid`  out  1  response slot full.
- `rsp0_ready`, `rsp1_ready`  in  1  consumer takes response.
- `rsp0_data`, `rsp1_data`  out  WIDTH  registered ALU result.
- `alu_op`  out  OPW  to shared ALU.
- `alu_a`, `alu_b`  out  WIDTH  to shared ALU.
- `alu_out`  in  WIDTH  combinational ALU result.

## Operation
- Slot i can accept when `free_i = !rsp_i_valid | rsp_i_ready` (same-cycle drain-and-refill allowed).
- Eligible_i = `req_i_valid & free_i`. At most one grant per cycle.
- Round-robin: `last` register (reset 1). If both eligible, grant the port != `last`; if one eligible, grant it. `last` updates to the granted port only on a grant.
- `req_i_ready = grant_i`. Ready depends on valids; requesters must not make valid depend on ready. Once asserted, valid and payload hold until accepted.
- Mux: granted port's op/a/b drive `alu_op/alu_a/alu_b`. No grant: `alu_op = ALU_ADD`, `alu_a = alu_b = 0`.
- On grant_i: `rsp_i_data <= alu_out`, `rsp_i_valid <= 1`.
- Without a grant, `rsp_i_valid` clears on `rsp_i_ready`. Data holds while valid and not taken.
- Non-granted eligible port stalls (ready=0). Starvation bounded to 1 cycle while its slot stays free.
- op codes pass through unchecked; `ALU_XXX` gives whatever the ALU returns.

## Timing
- Reset: `rsp*_valid=0`, `rsp*_data=0`, `req*_ready=0` (combinational off reset state; held 0 while `rst`), `last=1`, ALU outputs at idle values.
- Latency: accept at edge N → `rsp_valid`/data visible after edge N (cycle N+1). Throughput: 1 op/cycle aggregate, 1 op/cycle per port when alone with consumer always ready.
- Back-to-back same port: allowed every cycle if `rsp_i_ready` held high.
- Full slot with `rsp_i_ready=0`: port not eligible; other port may be granted that cycle.
- Both valid, both free, alternating: grants strictly alternate 0,1,0,1 starting with 0 after reset.
- `rst` mid-operation: in-flight responses discarded, slots emptied, `last=1` next cycle; no grant during `rst` cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: port 0 always wins when both eligible; `last` register not implemented. Port 1 may starve.
- Undefined (default): round-robin as above.

## Test plan
- Reset then port 0 only, op ALU_ADD a=5 b=7 → `req0_ready=1` same cycle; next cycle `rsp0_valid=1`, `rsp0_data=12`; port 1 outputs idle.
- Both valid continuously, consumers always ready, port0 ALU_SUB 10-3, port1 ALU_XOR 0xF0^0x0F → grants 0,1,0,1…; rsp0=7, rsp1=0xFF alternately, one accept per cycle total.
- Port 0 slot full, `rsp0_ready=0`, both valid → only port 1 granted every cycle; `rsp0_data` stable; on `rsp0_ready=1` port 0 granted by round-robin, drain and refill same cycle.
- Single port streaming with `rsp_ready=1`: 8 ops in 8 consecutive cycles, results in order, no bubble.
- Assert `rst` one cycle with both slots full → next cycle `rsp*_valid=0`; first contested grant goes to port 0.
- With `ALU_ARB_FIXED_PRIO_EN` defined, both valid 4 cycles → port 0 granted all 4 cycles, `req1_ready=0` throughout.
